// File: rtl/phys_reg_file_fl_if.sv
// phys_reg_file_fl_if: alloc/free, operand read and commit ports between issue logic, SICs and the register file
interface phys_reg_file_fl_if #(
    parameter int NUM_PHY_REGS = 64,
    parameter int DATA_W       = 32,
    parameter int NUM_SICS     = 2
);
    localparam int PW = $clog2(NUM_PHY_REGS);
    localparam int CW = $clog2(NUM_PHY_REGS + 1);
    logic [NUM_SICS-1:0]             alloc_req, alloc_gnt, free_wen, wcommit, rs_valid, rt_valid;
    logic [NUM_SICS-1:0][PW-1:0]     alloc_pr, free_pr, rs_addr, rt_addr, waddr;
    logic [NUM_SICS-1:0][DATA_W-1:0] wdata, rs_rdata, rt_rdata;
    logic [CW-1:0]                   free_count;
    logic [3:0]                      err_flags;
    modport master (
        output alloc_req, free_wen, free_pr, rs_addr, rt_addr, wcommit, waddr, wdata,
        input  alloc_gnt, alloc_pr, rs_rdata, rs_valid, rt_rdata, rt_valid, free_count, err_flags
    );
    modport slave (
        input  alloc_req, free_wen, free_pr, rs_addr, rt_addr, wcommit, waddr, wdata,
        output alloc_gnt, alloc_pr, rs_rdata, rs_valid, rt_rdata, rt_valid, free_count, err_flags
    );
endinterface

// File: rtl/phys_reg_file_fl.sv
// phys_reg_file_fl: physical register file with FIFO free list, in-use/valid tracking, commit bypass and sticky error flags
module phys_reg_file_fl #(
    parameter int NUM_PHY_REGS  = 64,
    parameter int NUM_ARCH_REGS = 32,
    parameter int DATA_W        = 32,
    parameter int NUM_SICS      = 2
) (
    input logic clk,
    input logic rst,
    phys_reg_file_fl_if.slave bus
);
    localparam int N  = NUM_PHY_REGS;
    localparam int S  = NUM_SICS;
    localparam int PW = $clog2(NUM_PHY_REGS);
    localparam int CW = $clog2(NUM_PHY_REGS + 1);

    logic [DATA_W-1:0]           regs_q [N];
    logic [PW-1:0]               fifo_q [N];
    logic [N-1:0]                vld_q, inuse_q;
    logic [PW-1:0]               head_q, tail_q;
    logic [CW-1:0]               count_q;
    logic [3:0]                  err_q, err_d;
    logic [S-1:0]                gnt, free_acc, cmt_acc, rs_v, rt_v;
    logic [S-1:0][PW-1:0]        pr_w, free_pos;
    logic [S-1:0][DATA_W-1:0]    rs_d, rt_d;
    logic [CW-1:0]               n_gnt, n_free;

    // Grants only see the pre-edge count, so same-cycle frees cannot be handed out yet
    always_comb begin
        gnt = '0;
        pr_w = '0;
        free_acc = '0;
        free_pos = '0;
        cmt_acc = '0;
        n_gnt = '0;
        n_free = '0;
        err_d = err_q;
        for (int s = 0; s < S; s++) begin
            if (bus.alloc_req[s] && n_gnt < count_q) begin
                gnt[s] = 1'b1;
                pr_w[s] = fifo_q[PW'((int'(head_q) + int'(n_gnt)) % N)];
                err_d[3] = err_d[3] | inuse_q[pr_w[s]];
                n_gnt = n_gnt + CW'(1);
            end
            free_acc[s] = bus.free_wen[s] && inuse_q[bus.free_pr[s]];
            for (int j = 0; j < s; j++)
                if (bus.free_wen[j] && bus.free_pr[j] == bus.free_pr[s]) free_acc[s] = 1'b0;
            free_pos[s] = PW'((int'(tail_q) + int'(n_free)) % N);
            n_free = n_free + CW'(free_acc[s]);
            err_d[2] = err_d[2] | (bus.free_wen[s] & ~free_acc[s]);
            cmt_acc[s] = bus.wcommit[s] && inuse_q[bus.waddr[s]];
            err_d[1] = err_d[1] | (bus.wcommit[s] & ~inuse_q[bus.waddr[s]]);
            err_d[0] = err_d[0] | (cmt_acc[s] & vld_q[bus.waddr[s]]);
            for (int j = 0; j < s; j++)
                if (cmt_acc[j] && cmt_acc[s] && bus.waddr[j] == bus.waddr[s]) err_d[0] = 1'b1;
        end
    end

    // Later SICs override earlier ones so the bypass matches which write lands
    always_comb begin
        for (int s = 0; s < S; s++) begin
            rs_d[s] = regs_q[bus.rs_addr[s]];
            rs_v[s] = vld_q[bus.rs_addr[s]];
            rt_d[s] = regs_q[bus.rt_addr[s]];
            rt_v[s] = vld_q[bus.rt_addr[s]];
            for (int c = 0; c < S; c++) begin
                if (cmt_acc[c] && bus.waddr[c] == bus.rs_addr[s]) begin
                    rs_d[s] = bus.wdata[c];
                    rs_v[s] = 1'b1;
                end
                if (cmt_acc[c] && bus.waddr[c] == bus.rt_addr[s]) begin
                    rt_d[s] = bus.wdata[c];
                    rt_v[s] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < N; p++) begin
                regs_q[p] <= '0;
                fifo_q[p] <= (p < N - NUM_ARCH_REGS) ? PW'(p + NUM_ARCH_REGS) : '0;
                vld_q[p] <= p < NUM_ARCH_REGS;
                inuse_q[p] <= p < NUM_ARCH_REGS;
            end
            head_q <= '0;
            tail_q <= PW'((N - NUM_ARCH_REGS) % N);
            count_q <= CW'(N - NUM_ARCH_REGS);
            err_q <= '0;
        end else begin
            for (int s = 0; s < S; s++) begin
                if (cmt_acc[s]) begin
                    regs_q[bus.waddr[s]] <= bus.wdata[s];
                    vld_q[bus.waddr[s]] <= 1'b1;
                end
            end
            for (int s = 0; s < S; s++) begin
                if (free_acc[s]) begin
                    fifo_q[free_pos[s]] <= bus.free_pr[s];
                    inuse_q[bus.free_pr[s]] <= 1'b0;
                end
            end
            for (int s = 0; s < S; s++) begin
                if (gnt[s]) begin
                    inuse_q[pr_w[s]] <= 1'b1;
                    vld_q[pr_w[s]] <= 1'b0;
                end
            end
            head_q <= PW'((int'(head_q) + int'(n_gnt)) % N);
            tail_q <= PW'((int'(tail_q) + int'(n_free)) % N);
            count_q <= count_q - n_gnt + n_free;
            err_q <= err_d;
        end
    end

    assign bus.alloc_gnt  = gnt;
    assign bus.alloc_pr   = pr_w;
    assign bus.rs_rdata   = rs_d;
    assign bus.rs_valid   = rs_v;
    assign bus.rt_rdata   = rt_d;
    assign bus.rt_valid   = rt_v;
    assign bus.free_count = count_q;
    assign bus.err_flags  = err_q;
endmodule

// File: tb/tb_phys_reg_file_fl.sv
// tb_phys_reg_file_fl: directed lifecycle vectors plus a randomized burst against a queue-based reference
module tb_phys_reg_file_fl;
    localparam int N = 64, A = 32, DW = 32, S = 2, PW = 6, CW = 7;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0, n_err = 0;
    int m_fifo[$];
    logic m_inuse [N];
    logic m_vld [N];
    logic [DW-1:0] m_regs [N];
    logic [3:0] m_err;

    phys_reg_file_fl_if #(.NUM_PHY_REGS(N), .DATA_W(DW), .NUM_SICS(S)) bus ();
    phys_reg_file_fl #(.NUM_PHY_REGS(N), .NUM_ARCH_REGS(A), .DATA_W(DW), .NUM_SICS(S))
        dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_req = '0;
        bus.free_wen = '0;
        bus.free_pr = '0;
        bus.wcommit = '0;
        bus.waddr = '0;
        bus.wdata = '0;
        bus.rs_addr = '0;
        bus.rt_addr = '0;
    endtask

    task automatic m_reset();
        m_fifo.delete();
        for (int p = A; p < N; p++) m_fifo.push_back(p);
        for (int p = 0; p < N; p++) begin
            m_inuse[p] = p < A;
            m_vld[p] = p < A;
            m_regs[p] = '0;
        end
        m_err = '0;
    endtask

    function automatic void exp_rd(input logic [PW-1:0] addr, input logic [S-1:0] ca,
                                   output logic [DW-1:0] d, output logic v);
        d = m_regs[addr];
        v = m_vld[addr];
        for (int s = 0; s < S; s++)
            if (ca[s] && bus.waddr[s] == addr) begin
                d = bus.wdata[s];
                v = 1'b1;
            end
    endfunction

    task automatic rand_cycle(input int c);
        int inl[$];
        int k;
        logic [S-1:0] ca, fa, g;
        logic [PW-1:0] gp [S];
        logic [DW-1:0] ed;
        logic ev;
        for (int p = 0; p < N; p++) if (m_inuse[p]) inl.push_back(p);
        for (int s = 0; s < S; s++) begin
            bus.alloc_req[s] = $urandom_range(0, 1) == 1;
            bus.free_wen[s] = inl.size() > 0 && $urandom_range(0, 1) == 1;
            bus.free_pr[s] = inl.size() > 0 ? PW'(inl[$urandom_range(0, inl.size() - 1)]) : '0;
            bus.wcommit[s] = $urandom_range(0, 1) == 1;
            bus.waddr[s] = (inl.size() == 0 || $urandom_range(0, 7) == 0) ? PW'($urandom_range(0, N - 1))
                                                                            : PW'(inl[$urandom_range(0, inl.size() - 1)]);
            bus.wdata[s] = $urandom;
        end
        for (int s = 0; s < S; s++) begin
            bus.rs_addr[s] = $urandom_range(0, 1) == 1 ? bus.waddr[$urandom_range(0, 1)] : PW'($urandom_range(0, N - 1));
            bus.rt_addr[s] = PW'($urandom_range(0, N - 1));
        end
        #1;
        k = 0;
        for (int s = 0; s < S; s++) begin
            g[s] = bus.alloc_req[s] && k < m_fifo.size();
            gp[s] = g[s] ? PW'(m_fifo[k]) : '0;
            if (g[s]) k++;
            chk($sformatf("r%0d gnt%0d", c, s), 64'(bus.alloc_gnt[s]), 64'(g[s]));
            chk($sformatf("r%0d pr%0d", c, s), 64'(bus.alloc_pr[s]), 64'(gp[s]));
            ca[s] = bus.wcommit[s] && m_inuse[bus.waddr[s]];
        end
        for (int s = 0; s < S; s++) begin
            exp_rd(bus.rs_addr[s], ca, ed, ev);
            chk($sformatf("r%0d rs%0d", c, s), {31'(0), bus.rs_valid[s], bus.rs_rdata[s]}, {31'(0), ev, ed});
            exp_rd(bus.rt_addr[s], ca, ed, ev);
            chk($sformatf("r%0d rt%0d", c, s), {31'(0), bus.rt_valid[s], bus.rt_rdata[s]}, {31'(0), ev, ed});
        end
        chk($sformatf("r%0d count", c), 64'(bus.free_count), 64'(m_fifo.size()));
        chk($sformatf("r%0d err", c), 64'(bus.err_flags), 64'(m_err));
        for (int s = 0; s < S; s++) begin
            if (bus.wcommit[s] && !ca[s]) m_err[1] = 1'b1;
            if (ca[s] && m_vld[bus.waddr[s]]) m_err[0] = 1'b1;
            fa[s] = bus.free_wen[s] && m_inuse[bus.free_pr[s]];
            for (int j = 0; j < s; j++) begin
                if (ca[j] && ca[s] && bus.waddr[j] == bus.waddr[s]) m_err[0] = 1'b1;
                if (bus.free_wen[j] && bus.free_pr[j] == bus.free_pr[s]) fa[s] = 1'b0;
            end
            if (bus.free_wen[s] && !fa[s]) m_err[2] = 1'b1;
            if (g[s] && m_inuse[gp[s]]) m_err[3] = 1'b1;
        end
        for (int s = 0; s < S; s++)
            if (ca[s]) begin
                m_regs[bus.waddr[s]] = bus.wdata[s];
                m_vld[bus.waddr[s]] = 1'b1;
            end
        for (int i = 0; i < k; i++) void'(m_fifo.pop_front());
        for (int s = 0; s < S; s++)
            if (fa[s]) begin
                m_fifo.push_back(int'(bus.free_pr[s]));
                m_inuse[bus.free_pr[s]] = 1'b0;
            end
        for (int s = 0; s < S; s++)
            if (g[s]) begin
                m_inuse[gp[s]] = 1'b1;
                m_vld[gp[s]] = 1'b0;
            end
        tick();
    endtask

    task automatic check_reset_view(input string tag);
        bus.rs_addr[0] = PW'(5);
        bus.rt_addr[0] = PW'(40);
        #1;
        chk({tag, " rs"}, {31'(0), bus.rs_valid[0], bus.rs_rdata[0]}, {31'(0), 1'b1, 32'h0});
        chk({tag, " rt_valid"}, 64'(bus.rt_valid[0]), 64'(0));
        chk({tag, " count"}, 64'(bus.free_count), 64'(32));
        chk({tag, " err"}, 64'(bus.err_flags), 64'(0));
    endtask

    initial begin
        idle();
        tick();
        tick();
        rst = 1'b0;
        // reset state
        check_reset_view("t1");
        chk("t1 no req gnt", 64'(bus.alloc_gnt), 64'(0));
        // dual alloc
        bus.alloc_req = 2'b11;
        #1;
        chk("t2 gnt", 64'(bus.alloc_gnt), 64'(2'b11));
        chk("t2 pr0", 64'(bus.alloc_pr[0]), 64'(32));
        chk("t2 pr1", 64'(bus.alloc_pr[1]), 64'(33));
        tick();
        chk("t2 count", 64'(bus.free_count), 64'(30));
        chk("t2 pr0 next", 64'(bus.alloc_pr[0]), 64'(34));
        chk("t2 pr1 next", 64'(bus.alloc_pr[1]), 64'(35));
        idle();
        // commit with same-cycle bypass, then double write
        bus.wcommit[0] = 1'b1;
        bus.waddr[0] = PW'(32);
        bus.wdata[0] = 32'hDEADBEEF;
        bus.rs_addr[1] = PW'(32);
        #1;
        chk("t3 bypass", {31'(0), bus.rs_valid[1], bus.rs_rdata[1]}, {31'(0), 1'b1, 32'hDEADBEEF});
        tick();
        bus.wcommit = '0;
        #1;
        chk("t3 stored", {31'(0), bus.rs_valid[1], bus.rs_rdata[1]}, {31'(0), 1'b1, 32'hDEADBEEF});
        chk("t3 err clean", 64'(bus.err_flags), 64'(0));
        bus.wcommit[0] = 1'b1;
        bus.wdata[0] = 32'h12345678;
        tick();
        bus.wcommit = '0;
        #1;
        chk("t3 double write err", 64'(bus.err_flags), 64'(4'b0001));
        chk("t3 data overwritten", 64'(bus.rs_rdata[1]), 64'(32'h12345678));
        // drain the free list
        idle();
        bus.alloc_req[0] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            #1;
            chk($sformatf("t4 drain pr %0d", i), {63'(bus.alloc_pr[0]), bus.alloc_gnt[0]}, {63'(34 + i), 1'b1});
            tick();
        end
        bus.alloc_req = 2'b11;
        #1;
        chk("t4 empty gnt", 64'(bus.alloc_gnt), 64'(0));
        chk("t4 empty pr", 64'(bus.alloc_pr), 64'(0));
        chk("t4 empty count", 64'(bus.free_count), 64'(0));
        bus.alloc_req = 2'b10;
        bus.free_wen[0] = 1'b1;
        bus.free_pr[0] = PW'(7);
        #1;
        chk("t4 free+alloc gnt", 64'(bus.alloc_gnt), 64'(0));
        tick();
        bus.free_wen = '0;
        #1;
        chk("t4 refill gnt", 64'(bus.alloc_gnt), 64'(2'b10));
        chk("t4 refill pr", 64'(bus.alloc_pr[1]), 64'(7));
        chk("t4 refill count", 64'(bus.free_count), 64'(1));
        tick();
        idle();
        #1;
        chk("t4 after realloc count", 64'(bus.free_count), 64'(0));
        // double free and commit to a free register
        bus.free_wen[0] = 1'b1;
        bus.free_pr[0] = PW'(40);
        tick();
        chk("t5 first free count", 64'(bus.free_count), 64'(1));
        chk("t5 first free err", 64'(bus.err_flags), 64'(4'b0001));
        tick();
        bus.free_wen = '0;
        #1;
        chk("t5 double free err", 64'(bus.err_flags), 64'(4'b0101));
        chk("t5 double free count", 64'(bus.free_count), 64'(1));
        bus.wcommit[0] = 1'b1;
        bus.waddr[0] = PW'(40);
        bus.wdata[0] = 32'hAAAA5555;
        bus.rs_addr[0] = PW'(40);
        #1;
        chk("t5 no bypass", 64'(bus.rs_valid[0]), 64'(0));
        tick();
        bus.wcommit = '0;
        #1;
        chk("t5 commit free err", 64'(bus.err_flags), 64'(4'b0111));
        chk("t5 vld40", {31'(0), bus.rs_valid[0], bus.rs_rdata[0]}, 64'(0));
        bus.free_wen = 2'b11;
        bus.free_pr[0] = PW'(41);
        bus.free_pr[1] = PW'(41);
        tick();
        idle();
        #1;
        chk("t5 same-cycle dup free count", 64'(bus.free_count), 64'(2));
        // randomized burst with a mid-burst reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_reset();
        for (int c = 0; c < 200; c++) begin
            if (c == 120) begin
                idle();
                rst = 1'b1;
                check_reset_view("t6 in reset");
                tick();
                rst = 1'b0;
                m_reset();
                check_reset_view("t6 after reset");
            end
            rand_cycle(c);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
